// File: rtl/proc_out_uart_tx.sv
// Trace serialiser for the processor out0 port: each changed value is queued and sent as four 8N1 bytes, LSB byte first.
// tx and all state are registered; a pushed word is popped on the following edge (no bypass).
module proc_out_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   data_in,
  output logic                          tx,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   DEPTH    = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q;
  logic [31:0]   last_q;
  logic [31:0]   shift_q;
  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  logic [1:0]    byte_q;
  logic [2:0]    bit_q;
  logic [BW-1:0] baud_q;
  logic          tx_q;
  logic          overflow_q;
  logic          push_req;
  logic          push_ok;
  logic          pop;
  logic          baud_end;
  logic [7:0]    cur_byte;

  assign push_req = (data_in != last_q);
  assign pop      = (state_q == IDLE) && (count_q != '0);
  // A full queue still accepts a word when the head leaves on the same edge.
  assign push_ok  = push_req && ((count_q != DEPTH) || pop);
  assign baud_end = (baud_q == BAUD_MAX);
  assign cur_byte = shift_q[{byte_q, 3'b000} +: 8];

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (pop && !push_ok) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      last_q  <= data_in;
      count_q <= count_d;
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end else if (push_req) begin
        overflow_q <= 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      byte_q  <= '0;
      bit_q   <= '0;
      baud_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q <= mem_q[rd_ptr_q];
            byte_q  <= '0;
            baud_q  <= '0;
            tx_q    <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (baud_end) begin
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= cur_byte[0];
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_q <= bit_q + 3'd1;
              tx_q  <= cur_byte[bit_q + 3'd1];
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_q <= '0;
            if (byte_q == 2'd3) begin
              state_q <= IDLE;
            end else begin
              byte_q  <= byte_q + 2'd1;
              tx_q    <= 1'b0;
              state_q <= START;
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx         = tx_q;
  assign busy       = (state_q != IDLE) || (count_q != '0);
  assign overflow   = overflow_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_proc_out_uart_tx.sv
// Bench for proc_out_uart_tx: a queue-and-timeline model of the serial line checked every cycle, plus literal spot checks.
module tb_proc_out_uart_tx;

  localparam int C  = 4;
  localparam int D  = 4;
  localparam int FR = 40 * C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data_in = '0;
  logic        tx;
  logic        busy;
  logic        overflow;
  logic [2:0]  fifo_count;

  always #5 clk = ~clk;

  proc_out_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .tx         (tx),
    .busy       (busy),
    .overflow   (overflow),
    .fifo_count (fifo_count)
  );

  int total = 0;
  int bad   = 0;

  // Model: queued words, the word on the line and the edge it was popped at.
  logic [31:0] mq[$];
  logic [31:0] m_last = '0;
  logic [31:0] m_word = '0;
  bit          m_act  = 1'b0;
  bit          m_ovf  = 1'b0;
  int          m_s    = 0;
  int          n      = 0;

  // Line level k cycles into a word: 4 frames of 10 bit-times each.
  function automatic logic exp_tx(input logic [31:0] w, input int k);
    int b;
    int p;
    if (k < 0 || k >= FR) return 1'b1;
    b = k / (10 * C);
    p = (k % (10 * C)) / C;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return w[b * 8 + p - 1];
  endfunction

  task automatic model_reset();
    mq.delete();
    m_last = '0;
    m_act  = 1'b0;
    m_ovf  = 1'b0;
  endtask

  task automatic model_step();
    bit pop;
    bit push_req;
    bit accept;
    n++;
    if (!rst) begin
      model_reset();
      return;
    end
    if (m_act && (n - 1 - m_s) >= FR) m_act = 1'b0;
    pop      = !m_act && (mq.size() > 0);
    push_req = (data_in != m_last);
    accept   = push_req && ((mq.size() < D) || pop);
    if (pop) begin
      m_word = mq.pop_front();
      m_s    = n;
      m_act  = 1'b1;
    end
    if (accept) mq.push_back(data_in);
    else if (push_req) m_ovf = 1'b1;
    m_last = data_in;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at cycle %0d", nm, act, exp, n);
    end
  endtask

  task automatic compare_all();
    logic etx;
    logic ebusy;
    etx   = m_act ? exp_tx(m_word, n - m_s) : 1'b1;
    ebusy = (m_act && (n - m_s) < FR) || (mq.size() != 0);
    chk("model_tx", tx, etx);
    chk("model_busy", busy, ebusy);
    chk("model_count", fifo_count, mq.size());
    chk("model_ovf", overflow, m_ovf);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  logic [31:0] vals [6];
  int          exp_cnt [6];

  initial begin
    int  off;
    bit  fell;
    bit  prev;
    int  rises;

    vals    = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66};
    exp_cnt = '{1, 1, 2, 3, 4, 4};

    // Reset state
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("reset_tx", tx, 1);
    chk("reset_busy", busy, 0);
    chk("reset_count", fifo_count, 0);
    chk("reset_ovf", overflow, 0);
    ticks(2);
    #2 rst = 1'b1;

    // Idle with zero input
    ticks(200);
    chk("idle_busy", busy, 0);
    chk("idle_tx", tx, 1);

    // Single word 0xA5
    data_in = 32'h0000_00A5;
    tick();
    chk("a5_e0_count", fifo_count, 1);
    chk("a5_e0_tx", tx, 1);
    tick();
    chk("a5_e1_tx", tx, 0);
    chk("a5_e1_count", fifo_count, 0);
    chk("a5_e1_busy", busy, 1);
    ticks(3);
    chk("a5_start_end_tx", tx, 0);
    tick();
    chk("a5_bit0", tx, 1);
    ticks(4);
    chk("a5_bit1", tx, 0);
    off  = 8;
    fell = 1'b0;
    for (int i = 0; i < 400 && !fell; i++) begin
      tick();
      off++;
      if (!busy) fell = 1'b1;
    end
    chk("a5_busy_fall_cycle", off, FR);

    // Held value sent once; rewriting it sends nothing
    data_in = 32'h1234_5678;
    prev  = busy;
    rises = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (busy && !prev) rises++;
      prev = busy;
    end
    chk("hold_one_tx", rises, 1);
    data_in = 32'h1234_5678;
    rises = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (busy && !prev) rises++;
      prev = busy;
    end
    chk("rewrite_no_tx", rises, 0);

    // Six values on consecutive edges: last one overflows
    for (int i = 0; i < 6; i++) begin
      data_in = vals[i];
      tick();
      chk("burst_count", fifo_count, exp_cnt[i]);
      chk("burst_ovf", overflow, (i == 5) ? 1 : 0);
    end
    ticks(5 * (FR + 1) + 10);
    chk("burst_drain_count", fifo_count, 0);
    chk("burst_drain_busy", busy, 0);
    chk("burst_ovf_sticky", overflow, 1);

    // Two queued words: one idle cycle between them
    data_in = 32'hAAAA_0001;
    tick();
    data_in = 32'hAAAA_0002;
    tick();
    ticks(159);
    chk("w1_last_stop_tx", tx, 1);
    chk("w1_last_stop_busy", busy, 1);
    tick();
    chk("gap_tx", tx, 1);
    chk("gap_count", fifo_count, 1);
    tick();
    chk("w2_start_tx", tx, 0);
    chk("w2_start_count", fifo_count, 0);
    ticks(FR + 10);

    // Asynchronous reset mid-DATA, then restart with 0x5 held
    data_in = 32'hF0F0_F0F0;
    tick();
    tick();
    ticks(10);
    chk("pre_reset_tx", tx, 0);
    rst = 1'b0;
    #1;
    model_reset();
    chk("async_tx", tx, 1);
    chk("async_count", fifo_count, 0);
    chk("async_ovf", overflow, 0);
    chk("async_busy", busy, 0);
    data_in = 32'h0000_0005;
    ticks(2);
    #2 rst = 1'b1;
    tick();
    chk("rel_e0_count", fifo_count, 1);
    chk("rel_e0_tx", tx, 1);
    tick();
    chk("rel_e1_tx", tx, 0);
    ticks(FR + 10);
    chk("rel_done_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
